// File: rtl/cache_fill_ctrl_if.sv
// Bus between the cache, the fill controller and main memory: the miss request,
// the memory read port and the data/tag array write strobes.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [15:0]       memory_data;
  logic              memory_data_valid;
  logic              memory_read;
  logic [ADDR_W-1:0] memory_address;
  logic [15:0]       DataIn_DA;
  logic              write_data_array;
  logic [ADDR_W-1:0] fill_address;
  logic              write_tag_array;
  logic              fsm_busy;
  logic              fill_error;

  modport master (
    output miss_detected, miss_address, memory_data, memory_data_valid,
    input  memory_read, memory_address, DataIn_DA, write_data_array,
           fill_address, write_tag_array, fsm_busy, fill_error
  );

  modport slave (
    input  miss_detected, miss_address, memory_data, memory_data_valid,
    output memory_read, memory_address, DataIn_DA, write_data_array,
           fill_address, write_tag_array, fsm_busy, fill_error
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache miss fill controller: bursts WORDS reads to memory, streams returns into the
// data array, then pulses the tag write. Define CACHE_FILL_TIMEOUT_EN for the watchdog abort.
//
// state | meaning
// IDLE  | waiting for miss_detected
// FILL  | issuing reads and writing returned words
// DONE  | one-cycle tag install
module cache_fill_ctrl #(
  parameter int WORDS   = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst,
  cache_fill_ctrl_if.slave bus
);

  localparam int OFF_W = $clog2(2 * WORDS);
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

  if (WORDS < 1 || (WORDS & (WORDS - 1)) != 0) begin : g_bad_words
    $error("cache_fill_ctrl: WORDS must be a power of 2");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("cache_fill_ctrl: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              memory_read_q, memory_read_d;
  logic [ADDR_W-1:0] memory_address_q, memory_address_d;
  logic              write_tag_q, write_tag_d;
  logic              busy_q, busy_d;
  logic              ret_fire;

`ifdef CACHE_FILL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  // Abort two counts early so the registered pulse lands TIMEOUT cycles after the last return.
  localparam logic [WD_W-1:0] WD_FIRE = WD_W'(TIMEOUT - 2);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            fill_error_q, fill_error_d;
`endif

  assign ret_fire = (state_q == FILL) && bus.memory_data_valid && (ret_cnt_q < issue_cnt_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
`ifdef CACHE_FILL_TIMEOUT_EN
    wdog_d       = wdog_q;
    fill_error_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d     = FILL;
          base_d      = bus.miss_address & BASE_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
`ifdef CACHE_FILL_TIMEOUT_EN
          wdog_d      = '0;
`endif
        end
      end
      FILL: begin
        if (issue_cnt_q < WORDS_C) issue_cnt_d = issue_cnt_q + 1'b1;
        if (ret_fire) begin
          ret_cnt_d = ret_cnt_q + 1'b1;
          if (ret_cnt_q == LAST_C) state_d = DONE;
        end
`ifdef CACHE_FILL_TIMEOUT_EN
        if (ret_fire) begin
          wdog_d = '0;
        end else if (wdog_q == WD_FIRE) begin
          fill_error_d = 1'b1;
          state_d      = IDLE;
          issue_cnt_d  = '0;
          ret_cnt_d    = '0;
          wdog_d       = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Issue-side outputs are registered from the next-state view.
    memory_read_d    = (state_d == FILL) && (issue_cnt_d < WORDS_C);
    memory_address_d = memory_read_d ? base_d + (ADDR_W'(issue_cnt_d) << 1) : '0;
    write_tag_d      = (state_d == DONE);
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= IDLE;
      base_q           <= '0;
      issue_cnt_q      <= '0;
      ret_cnt_q        <= '0;
      memory_read_q    <= 1'b0;
      memory_address_q <= '0;
      write_tag_q      <= 1'b0;
      busy_q           <= 1'b0;
`ifdef CACHE_FILL_TIMEOUT_EN
      wdog_q           <= '0;
      fill_error_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      issue_cnt_q      <= issue_cnt_d;
      ret_cnt_q        <= ret_cnt_d;
      memory_read_q    <= memory_read_d;
      memory_address_q <= memory_address_d;
      write_tag_q      <= write_tag_d;
      busy_q           <= busy_d;
`ifdef CACHE_FILL_TIMEOUT_EN
      wdog_q           <= wdog_d;
      fill_error_q     <= fill_error_d;
`endif
    end
  end

  assign bus.memory_read      = memory_read_q;
  assign bus.memory_address   = memory_address_q;
  assign bus.write_tag_array  = write_tag_q;
  assign bus.fsm_busy         = busy_q;
  // Return side is combinational so a word is written in the cycle memory presents it.
  assign bus.DataIn_DA        = bus.memory_data;
  assign bus.write_data_array = ret_fire;
  assign bus.fill_address     = ret_fire ? base_q + (ADDR_W'(ret_cnt_q) << 1) : '0;
`ifdef CACHE_FILL_TIMEOUT_EN
  assign bus.fill_error       = fill_error_q;
`else
  assign bus.fill_error       = 1'b0;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: latency-based memory model, scoreboard queues for
// read addresses and array writes, and cycle-accurate checks on the control pulses.
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDR_W(16)) bus ();

  cache_fill_ctrl #(.WORDS(8), .ADDR_W(16), .TIMEOUT(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {logic [15:0] a; logic [15:0] d;} wexp_t;
  typedef struct {logic [15:0] addr; int c;} req_t;

  logic [15:0] exp_rd[$];
  wexp_t       exp_wr[$];
  req_t        pend[$];
  int rd_cycles[$], wr_cycles[$], tag_cycles[$], err_cycles[$];
  int sched[$];
  int lat = 4;
  bit use_sched = 1'b0;
  bit force_valid = 1'b0;
  int sched_t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_sched(input int r);
    foreach (sched[i]) if (sched[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rel(input int q[$], input int i, input int c0);
    if (i >= q.size()) return -1;
    return q[i] - c0;
  endfunction

  function automatic logic [4:0] ctl_outs();
    return {bus.memory_read, bus.write_data_array, bus.write_tag_array, bus.fsm_busy, bus.fill_error};
  endfunction

  // Memory model: requests return after lat cycles, optionally only on scheduled cycles.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;
    if (!rst) begin
      pend.delete();
    end else begin
      if (force_valid) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'hDEAD;
      end else if (pend.size() > 0 && pend[0].c + lat <= cyc &&
                   (!use_sched || in_sched(cyc - sched_t0))) begin
        bus.memory_data_valid = 1'b1;
        bus.memory_data       = 16'hA000 + ((pend[0].addr >> 1) & 16'h0007);
        void'(pend.pop_front());
      end
      if (bus.memory_read) pend.push_back('{addr: bus.memory_address, c: cyc});
    end
  end

  // Scoreboard side: every read and write the DUT produces is matched against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.memory_read) begin
        rd_cycles.push_back(cyc);
        chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) chk("rd_addr", 32'(bus.memory_address), 32'(exp_rd.pop_front()));
      end
      if (bus.write_data_array) begin
        wexp_t e;
        wr_cycles.push_back(cyc);
        chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.fill_address), 32'(e.a));
          chk("wr_data", 32'(bus.DataIn_DA), 32'(e.d));
        end
      end
      if (bus.write_tag_array) tag_cycles.push_back(cyc);
      if (bus.fill_error) err_cycles.push_back(cyc);
    end
  end

  task automatic push_exp(input logic [15:0] addr);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_rd.push_back(base + 16'(2 * k));
      exp_wr.push_back({base + 16'(2 * k), 16'hA000 + 16'(k)});
    end
  endtask

  task automatic clear_logs();
    rd_cycles.delete(); wr_cycles.delete(); tag_cycles.delete(); err_cycles.delete();
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start_fill(input logic [15:0] addr, output int c0);
    @(negedge clk); #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    c0 = cyc;
    sched_t0 = cyc;
    push_exp(addr);
  endtask

  task automatic drop_miss();
    @(negedge clk); #1;
    bus.miss_detected = 1'b0;
  endtask

  initial begin
    int c0, c1;
    rst = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 32'(ctl_outs()), 32'd0);
    chk("reset_maddr", 32'(bus.memory_address), 32'd0);
    chk("reset_faddr", 32'(bus.fill_address), 32'd0);
    #1 rst = 1'b1;

    // spurious valid while idle
    clear_logs();
    @(negedge clk); #1 force_valid = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 3; i++) begin
      at_cycle(c0 + i);
      chk("spur_idle_wr", 32'(bus.write_data_array), 32'd0);
    end
    #1 force_valid = 1'b0;
    chk("spur_idle_busy", 32'(bus.fsm_busy), 32'd0);

    // basic fill, plus a spurious valid in DONE
    clear_logs();
    start_fill(16'h1236, c0);
    drop_miss();
    at_cycle(c0 + 12); #1 force_valid = 1'b1;
    at_cycle(c0 + 13);
    chk("basic_tag_c13", 32'(bus.write_tag_array), 32'd1);
    chk("basic_busy_c13", 32'(bus.fsm_busy), 32'd1);
    chk("spur_done_wr", 32'(bus.write_data_array), 32'd0);
    #1 force_valid = 1'b0;
    at_cycle(c0 + 14);
    chk("basic_busy_c14", 32'(bus.fsm_busy), 32'd0);
    chk("basic_rd_n", 32'(rd_cycles.size()), 32'd8);
    chk("basic_rd_first", 32'(rel(rd_cycles, 0, c0)), 32'd1);
    chk("basic_rd_last", 32'(rel(rd_cycles, 7, c0)), 32'd8);
    chk("basic_wr_n", 32'(wr_cycles.size()), 32'd8);
    chk("basic_wr_first", 32'(rel(wr_cycles, 0, c0)), 32'd5);
    chk("basic_wr_last", 32'(rel(wr_cycles, 7, c0)), 32'd12);
    chk("basic_tag_n", 32'(tag_cycles.size()), 32'd1);
    chk("basic_tag_cyc", 32'(rel(tag_cycles, 0, c0)), 32'd13);
    chk("basic_wr_left", 32'(exp_wr.size()), 32'd0);

    // back-to-back: miss held high, address changes after acceptance
    clear_logs();
    start_fill(16'h0010, c0);
    @(negedge clk); #1;
    bus.miss_address = 16'h4F02;
    push_exp(16'h4F02);
    at_cycle(c0 + 14);
    chk("b2b_busy_c14", 32'(bus.fsm_busy), 32'd0);
    at_cycle(c0 + 15);
    chk("b2b_rd2_addr", 32'(bus.memory_address), 32'h4F00);
    #1 bus.miss_detected = 1'b0;
    at_cycle(c0 + 28);
    chk("b2b_tag_n", 32'(tag_cycles.size()), 32'd2);
    chk("b2b_tag1", 32'(rel(tag_cycles, 0, c0)), 32'd13);
    chk("b2b_tag2", 32'(rel(tag_cycles, 1, c0)), 32'd27);
    chk("b2b_rd2_first", 32'(rel(rd_cycles, 8, c0)), 32'd15);
    chk("b2b_wr_n", 32'(wr_cycles.size()), 32'd16);
    chk("b2b_busy_c28", 32'(bus.fsm_busy), 32'd0);
    chk("b2b_wr_left", 32'(exp_wr.size()), 32'd0);

    // irregular memory returns
    clear_logs();
    sched = '{5, 7, 8, 12, 13, 15, 16, 20};
    use_sched = 1'b1;
    start_fill(16'h2A5C, c0);
    drop_miss();
    at_cycle(c0 + 22);
    chk("irr_wr_n", 32'(wr_cycles.size()), 32'd8);
    foreach (sched[i]) chk("irr_wr_cyc", 32'(rel(wr_cycles, i, c0)), 32'(sched[i]));
    chk("irr_tag_n", 32'(tag_cycles.size()), 32'd1);
    chk("irr_tag_cyc", 32'(rel(tag_cycles, 0, c0)), 32'd21);
    chk("irr_busy_c22", 32'(bus.fsm_busy), 32'd0);
    use_sched = 1'b0;

    // reset after the third returned word
    clear_logs();
    start_fill(16'h7FF8, c0);
    drop_miss();
    at_cycle(c0 + 7); #1 rst = 1'b0;
    at_cycle(c0 + 8);
    chk("rstmid_ctl", 32'(ctl_outs()), 32'd0);
    chk("rstmid_maddr", 32'(bus.memory_address), 32'd0);
    chk("rstmid_faddr", 32'(bus.fill_address), 32'd0);
    chk("rstmid_wr_n", 32'(wr_cycles.size()), 32'd3);
    exp_rd.delete();
    exp_wr.delete();
    #1 rst = 1'b1;
    at_cycle(c0 + 20);
    chk("rstmid_no_tag", 32'(tag_cycles.size()), 32'd0);
    chk("rstmid_busy", 32'(bus.fsm_busy), 32'd0);
    clear_logs();
    start_fill(16'h3332, c1);
    drop_miss();
    at_cycle(c1 + 14);
    chk("refill_wr_n", 32'(wr_cycles.size()), 32'd8);
    chk("refill_tag_cyc", 32'(rel(tag_cycles, 0, c1)), 32'd13);
    chk("refill_wr_left", 32'(exp_wr.size()), 32'd0);

    // memory stops after five words
    clear_logs();
    sched = '{5, 6, 7, 8, 9};
    use_sched = 1'b1;
    start_fill(16'h5550, c0);
    drop_miss();
`ifdef CACHE_FILL_TIMEOUT_EN
    at_cycle(c0 + 72);
    chk("wd_busy_c72", 32'(bus.fsm_busy), 32'd1);
    chk("wd_err_c72", 32'(bus.fill_error), 32'd0);
    at_cycle(c0 + 73);
    chk("wd_err_c73", 32'(bus.fill_error), 32'd1);
    chk("wd_busy_c73", 32'(bus.fsm_busy), 32'd0);
    chk("wd_rd_c73", 32'(bus.memory_read), 32'd0);
    at_cycle(c0 + 80);
    chk("wd_err_n", 32'(err_cycles.size()), 32'd1);
    chk("wd_err_cyc", 32'(rel(err_cycles, 0, c0)), 32'd73);
    chk("wd_busy_c80", 32'(bus.fsm_busy), 32'd0);
`else
    at_cycle(c0 + 80);
    chk("stall_busy", 32'(bus.fsm_busy), 32'd1);
    chk("stall_err_n", 32'(err_cycles.size()), 32'd0);
`endif
    chk("stall_wr_n", 32'(wr_cycles.size()), 32'd5);
    chk("stall_no_tag", 32'(tag_cycles.size()), 32'd0);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    exp_rd.delete();
    exp_wr.delete();
    use_sched = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
Memory-side responder for the data cache miss path. It accepts a miss request and its address from the cache, then issues a burst of word reads to the multi-cycle pipelined main memory. Each returned word is streamed into the data array with write_data_array and a word address. After the last word it pulses write_tag_array so the cache installs the tag, valid and LRU bits in the way it selected. One instance sits between the data cache and the memory; a second identical instance serves the instruction cache.

Parameters:
WORDS, 8, 16-bit words per cache block; must be a power of 2; the block is 2*WORDS bytes.
ADDR_W, 16, byte-address width.
TIMEOUT, 64, idle-cycle limit for the optional watchdog; must be at least 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous active-low reset.
miss_detected  input  1  cache miss request; level, sampled only in IDLE.
miss_address  input  ADDR_W  byte address of the missing access.
memory_data  input  16  read data returned by memory.
memory_data_valid  input  1  memory_data is valid this cycle.
memory_read  output  1  read request to memory this cycle.
memory_address  output  ADDR_W  read address presented to memory.
DataIn_DA  output  16  word to write into the data array; equals memory_data, combinational.
write_data_array  output  1  write one word into the data array this cycle.
fill_address  output  ADDR_W  byte address of the word being written; the cache decodes word enable from bits [3:1].
write_tag_array  output  1  one-cycle pulse: install the tag for the filled block.
fsm_busy  output  1  fill in progress; the cache stalls the pipeline while it is high.
fill_error  output  1  one-cycle pulse: fill aborted by the watchdog.

Behaviour:
- Reset: rst=0 at a clock edge forces IDLE, clears all counters and the base register, and drives every output to 0.
  - This applies mid-fill: the partial block stays in the array and no tag write is issued.
- State machine: IDLE, FILL, DONE (2-bit state register).
- Base address: base = miss_address with the low log2(2*WORDS) bits cleared; 0xFFF0 mask at the defaults.
- Counters: issue_cnt and ret_cnt, each log2(WORDS)+1 bits.
- IDLE:
  - fsm_busy=0.
  - If miss_detected=1, latch base, clear both counters and go to FILL.
- FILL (fsm_busy=1):
  - Issue side: memory_read = (issue_cnt < WORDS). memory_address = base + 2*issue_cnt when memory_read=1, otherwise 0. issue_cnt increments on each issue.
  - Return side: when memory_data_valid=1 and ret_cnt < issue_cnt, drive write_data_array=1 and fill_address = base + 2*ret_cnt, then increment ret_cnt.
  - When that accepted return is the last one (ret_cnt == WORDS-1), go to DONE.
  - Issue and return may occur in the same cycle.
- DONE: write_tag_array=1 and fsm_busy=1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - memory_data_valid is ignored in IDLE and DONE, and whenever ret_cnt >= issue_cnt (spurious return).
  - miss_detected is ignored outside IDLE, so a new miss is accepted no earlier than the first IDLE cycle after DONE.
- Address arithmetic: wraps within the block only; the base alignment guarantees no carry into the tag bits.
- Timing: with memory latency L, tag write occurs at acceptance + WORDS + L + 1 cycles.
- Non-fill outputs: when write_data_array=0, fill_address=0.

Optional Feature:
Macro CACHE_FILL_TIMEOUT_EN.
- Defined: a watchdog counter, log2(TIMEOUT)+1 bits, clears on FILL entry and on every accepted return, and otherwise increments in FILL.
  - When it reaches TIMEOUT, the block pulses fill_error for one cycle, returns to IDLE and issues no tag write.
  - Counters are cleared; outputs follow the IDLE rules in the same cycle as the pulse.
- Not defined: no watchdog logic is built, fill_error is tied to 0, and FILL waits indefinitely.

Test Plan:
- Basic fill (memory latency 4, data = 0xA000+word): miss at 0x1236 accepted in cycle 0 -> memory_read in cycles 1-8 at addresses 0x1230, 0x1232, ... 0x123E; write_data_array in cycles 5-12 with fill_address 0x1230..0x123E and DataIn_DA 0xA000..0xA007; write_tag_array in cycle 13 only; fsm_busy=0 in cycle 14.
- Back-to-back: miss_detected held high through the first fill at 0x0010 while miss_address changes to 0x4F02 -> second fill starts in cycle 14 at base 0x4F00; the first fill's writes are unaffected.
- Irregular memory: valid returns with gaps (cycles 5, 7, 8, 12, 13, 15, 16, 20) -> eight data writes at successive word addresses; tag pulse one cycle after the cycle-20 return.
- Spurious valid: memory_data_valid=1 in IDLE and in DONE -> no data writes, no counter change.
- Reset mid-fill: rst=0 after the third returned word -> next cycle all outputs 0 and state IDLE; no write_tag_array; the following miss fills normally.
- CACHE_FILL_TIMEOUT_EN defined with TIMEOUT=64: memory stops returning after word 5 -> fill_error pulses once 64 cycles after the last return, write_tag_array is never asserted, and fsm_busy falls with the pulse. Without the macro: fsm_busy stays 1 and fill_error stays 0.
